// File: rtl/mips_cpu_fetch_ctrl.sv
// Instruction fetch controller: reads the PC, fetches over the instruction bus,
// holds the word for decode and pulses update_pc once execution completes.
module mips_cpu_fetch_ctrl #(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
  parameter bit          BYTE_SWAP = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  output logic [31:0]      instr_address,
  output logic             instr_read,
  input  logic             instr_waitrequest,
  input  logic [31:0]      instr_readdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  output logic             update_pc,
  output logic             active,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC,
    UPDATE,
    HALTED
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] rd_w;
  logic        pc_halt;
  logic        pc_mis;
  logic        pc_ok;
  logic        xfer;

  assign pc_halt = (pc == HALT_ADDR);
  assign pc_mis  = (pc[1:0] != 2'b00);
  assign pc_ok   = !pc_halt && !pc_mis;

  // The request is raised in the FETCH entry cycle itself so a zero-wait
  // fetch completes on that edge; WAIT then holds the latched address.
  assign instr_read    = ((state == FETCH) && pc_ok) || (state == WAIT);
  assign instr_address = (state == FETCH) ? pc : addr_q;
  assign xfer          = instr_read && !instr_waitrequest;

  assign rd_w = BYTE_SWAP ? {instr_readdata[7:0],   instr_readdata[15:8],
                             instr_readdata[23:16], instr_readdata[31:24]}
                          : instr_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      update_pc   <= 1'b0;
      active      <= 1'b0;
      fault       <= 1'b0;
      retired     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          active <= 1'b1;
          state  <= FETCH;
        end
        FETCH: begin
          if (pc_halt) begin
            active <= 1'b0;
            state  <= HALTED;
          end else if (pc_mis) begin
            active <= 1'b0;
            fault  <= 1'b1;
            state  <= HALTED;
          end else begin
            addr_q <= pc;
            state  <= xfer ? EXEC : WAIT;
          end
        end
        WAIT: begin
          if (xfer) state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            update_pc   <= 1'b1;
            instr_valid <= 1'b0;
            if (retired != '1) retired <= retired + 1'b1;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          update_pc <= 1'b0;
          state     <= FETCH;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (xfer) begin
        instr       <= rd_w;
        instr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_fetch_ctrl.sv
// Bench for mips_cpu_fetch_ctrl: transaction-level model of memory, PC
// sequencing and retire counting, with directed and randomized instructions.
module tb_mips_cpu_fetch_ctrl;

  localparam int CNT_W = 4;
  localparam int RMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [31:0]      pc;
  logic [31:0]      instr_address;
  logic             instr_read;
  logic             waitreq;
  logic [31:0]      rd;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             exec_done;
  logic             update_pc;
  logic             active;
  logic             fault;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  mips_cpu_fetch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc                (pc),
    .instr_address     (instr_address),
    .instr_read        (instr_read),
    .instr_waitrequest (waitreq),
    .instr_readdata    (rd),
    .instr             (instr),
    .instr_valid       (instr_valid),
    .exec_done         (exec_done),
    .update_pc         (update_pc),
    .active            (active),
    .fault             (fault),
    .retired           (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h7856_3412;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] r;
    w = mem_word(a);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  // Data is garbage while stalled so an early capture shows up.
  assign rd = waitreq ? 32'hDEAD_BEEF : mem_word(instr_address);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset) chk("overlap", {31'd0, update_pc & instr_read}, 32'd0);

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_read"}, {31'd0, instr_read}, 32'd0);
    chk({tag, "_addr"}, instr_address, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_upd"}, {31'd0, update_pc}, 32'd0);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_ret"}, {28'd0, retired}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    waitreq = 1'b0;
    exec_done = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    exp_ret = 0;
  endtask

  // Returns at the negedge of the update_pc cycle.
  task automatic do_instr(input logic [31:0] a, input int ws, input int ed);
    int t;
    pc = a;
    waitreq = 1'b0;
    exec_done = 1'b0;
    t = 0;
    while (!instr_read && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("read_seen", {31'd0, instr_read}, 32'd1);
    for (int k = 0; k <= ws; k++) begin
      chk("read_hold", {31'd0, instr_read}, 32'd1);
      chk("addr_hold", instr_address, a);
      chk("no_valid", {31'd0, instr_valid}, 32'd0);
      chk("active_on", {31'd0, active}, 32'd1);
      waitreq = (k < ws);
      if (k >= 1) pc = $urandom;
      @(negedge clk);
    end
    waitreq = 1'b0;
    chk("read_drop", {31'd0, instr_read}, 32'd0);
    chk("instr", instr, exp_instr(a));
    for (int d = 0; d <= ed; d++) begin
      chk("exec_valid", {31'd0, instr_valid}, 32'd1);
      chk("exec_no_upd", {31'd0, update_pc}, 32'd0);
      exec_done = (d == ed);
      pc = $urandom;
      @(negedge clk);
    end
    exec_done = 1'b0;
    exp_ret = (exp_ret >= RMAX) ? RMAX : exp_ret + 1;
    chk("upd_pulse", {31'd0, update_pc}, 32'd1);
    chk("upd_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("retired", {28'd0, retired}, exp_ret);
  endtask

  initial begin
    logic [31:0] a;
    int last;
    int n;
    int cyc;
    reset = 1'b1;
    pc = 32'hBFC0_0000;
    waitreq = 1'b0;
    exec_done = 1'b0;

    do_reset();
    do_instr(32'hBFC0_0000, 0, 2);
    do_instr(32'hBFC0_0004, 3, 0);

    for (int i = 0; i < 16; i++) begin
      a = ($urandom | 32'h10) & 32'hFFFF_FFFC;
      do_instr(a, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    pc = 32'h0000_0000;
    @(negedge clk);
    chk("halt_no_read", {31'd0, instr_read}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("halt_read", {31'd0, instr_read}, 32'd0);
      chk("halt_active", {31'd0, active}, 32'd0);
      chk("halt_fault", {31'd0, fault}, 32'd0);
      chk("halt_ret", {28'd0, retired}, exp_ret);
    end

    do_reset();
    pc = 32'hBFC0_0002;
    @(negedge clk);
    chk("mis_no_read", {31'd0, instr_read}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      pc = 32'hBFC0_0100;
      chk("mis_read", {31'd0, instr_read}, 32'd0);
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_active", {31'd0, active}, 32'd0);
    end

    do_reset();
    do_instr(32'hBFC0_0040, 0, 0);
    pc = 32'hBFC0_0010;
    waitreq = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_read_pre", {31'd0, instr_read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("t5");
    reset = 1'b0;
    waitreq = 1'b0;
    exp_ret = 0;
    do_instr(32'hBFC0_0020, 1, 1);

    do_reset();
    pc = 32'h0000_1000;
    exec_done = 1'b1;
    last = -1;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (update_pc) begin
        if (last >= 0) chk("t6_period", cyc - last, 32'd3);
        last = cyc;
        n++;
        pc = pc + 32'd4;
      end
    end
    chk("t6_count", n, 32'd10);
    chk("t6_retired", {28'd0, retired}, 32'd10);
    exec_done = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
